// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between instruction fetch (read-only)
// and memory access (load/store); one outstanding transaction, MA priority, IF starvation guard.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_Addr,
  input  logic        IF_Req_Valid,
  output logic        IF_Req_Ready,
  output logic [31:0] IF_Read_data,
  output logic        IF_Read_data_Valid,
  input  logic        IF_Read_data_Ready,
  input  logic [31:0] MA_Addr,
  input  logic        MA_MemRead,
  input  logic        MA_MemWrite,
  input  logic [31:0] MA_Write_data,
  input  logic [3:0]  MA_Write_strb,
  output logic        MA_Req_Ready,
  output logic [31:0] MA_Read_data,
  output logic        MA_Read_data_Valid,
  input  logic        MA_Read_data_Ready,
  output logic [31:0] Address,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic        Mem_Req_Ready,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ready,
  output logic [31:0] Conflict_Cnt
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [3:0] STC_MAX = 4'(STARVE_LIMIT);
  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_MA  = 1'b1;

  state_t      state_reg, state_next;
  logic        own_reg, own_next;
  logic [3:0]  stc_reg, stc_next;
  logic [31:0] ar_reg, ar_next;
  logic        wr_reg, wr_next;
  logic [31:0] dr_reg, dr_next;
  logic [3:0]  sr_reg, sr_next;
  logic [31:0] conflict_cnt_reg, conflict_cnt_next;

  logic ma_req;
  logic conflict;
  logic if_win;
  logic ma_win;
  logic owner_ready;

  assign ma_req      = MA_MemRead | MA_MemWrite;
  assign conflict    = IF_Req_Valid & ma_req;
  assign if_win      = IF_Req_Valid & (~ma_req | (stc_reg == STC_MAX));
  assign ma_win      = ma_req & ~if_win;
  assign owner_ready = (own_reg == OWN_MA) ? MA_Read_data_Ready : IF_Read_data_Ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      own_reg          <= OWN_IF;
      stc_reg          <= 4'd0;
      ar_reg           <= 32'd0;
      wr_reg           <= 1'b0;
      dr_reg           <= 32'd0;
      sr_reg           <= 4'd0;
      conflict_cnt_reg <= 32'd0;
    end else begin
      state_reg        <= state_next;
      own_reg          <= own_next;
      stc_reg          <= stc_next;
      ar_reg           <= ar_next;
      wr_reg           <= wr_next;
      dr_reg           <= dr_next;
      sr_reg           <= sr_next;
      conflict_cnt_reg <= conflict_cnt_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    own_next          = own_reg;
    stc_next          = stc_reg;
    ar_next           = ar_reg;
    wr_next           = wr_reg;
    dr_next           = dr_reg;
    sr_next           = sr_reg;
    conflict_cnt_next = conflict_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (conflict) conflict_cnt_next = conflict_cnt_reg + 32'd1;
        if (if_win) begin
          own_next   = OWN_IF;
          ar_next    = IF_Addr;
          wr_next    = 1'b0;
          dr_next    = 32'd0;
          sr_next    = 4'd0;
          stc_next   = 4'd0;
          state_next = REQ;
        end else if (ma_win) begin
          own_next   = OWN_MA;
          ar_next    = MA_Addr;
          wr_next    = MA_MemWrite;
          dr_next    = MA_Write_data;
          sr_next    = MA_Write_strb;
          // Only an MA win that made IF wait counts toward starvation.
          if (IF_Req_Valid && (stc_reg < STC_MAX)) stc_next = stc_reg + 4'd1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (Mem_Req_Ready) state_next = wr_reg ? IDLE : RESP;
      end
      RESP: begin
        if (Read_data_Valid && owner_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // State sits at IDLE during reset, so grants are also masked by rst.
    IF_Req_Ready       = rst & (state_reg == IDLE) & if_win;
    MA_Req_Ready       = rst & (state_reg == IDLE) & ma_win;
    Address            = ar_reg;
    Write_data         = dr_reg;
    MemRead            = (state_reg == REQ) & ~wr_reg;
    MemWrite           = (state_reg == REQ) & wr_reg;
    Write_strb         = (state_reg == REQ) ? sr_reg : 4'd0;
    Read_data_Ready    = (state_reg == RESP) & owner_ready;
    IF_Read_data_Valid = (state_reg == RESP) & (own_reg == OWN_IF) & Read_data_Valid;
    MA_Read_data_Valid = (state_reg == RESP) & (own_reg == OWN_MA) & Read_data_Valid;
    IF_Read_data       = Read_data;
    MA_Read_data       = Read_data;
    Conflict_Cnt       = conflict_cnt_reg;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of granted requests checked
// against the memory channel, plus response routing, arbitration order and reset.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic [31:0] IF_Addr;
  logic        IF_Req_Valid;
  logic        IF_Req_Ready;
  logic [31:0] IF_Read_data;
  logic        IF_Read_data_Valid;
  logic        IF_Read_data_Ready;
  logic [31:0] MA_Addr;
  logic        MA_MemRead;
  logic        MA_MemWrite;
  logic [31:0] MA_Write_data;
  logic [3:0]  MA_Write_strb;
  logic        MA_Req_Ready;
  logic [31:0] MA_Read_data;
  logic        MA_Read_data_Valid;
  logic        MA_Read_data_Ready;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic [31:0] Conflict_Cnt;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .IF_Addr(IF_Addr), .IF_Req_Valid(IF_Req_Valid), .IF_Req_Ready(IF_Req_Ready),
    .IF_Read_data(IF_Read_data), .IF_Read_data_Valid(IF_Read_data_Valid),
    .IF_Read_data_Ready(IF_Read_data_Ready),
    .MA_Addr(MA_Addr), .MA_MemRead(MA_MemRead), .MA_MemWrite(MA_MemWrite),
    .MA_Write_data(MA_Write_data), .MA_Write_strb(MA_Write_strb), .MA_Req_Ready(MA_Req_Ready),
    .MA_Read_data(MA_Read_data), .MA_Read_data_Valid(MA_Read_data_Valid),
    .MA_Read_data_Ready(MA_Read_data_Ready),
    .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite), .Write_data(Write_data),
    .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .Conflict_Cnt(Conflict_Cnt)
  );

  typedef struct {
    logic        own;   // 0 = IF, 1 = MA
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  txn_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          txn_no = 0;
  int          stc_m  = 0;
  logic [31:0] cc_m   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with requests already driven; predicts the winner,
  // checks the handshake and pushes the expected memory request.
  task automatic grant_step();
    txn_t e;
    logic ma_r;
    logic exp_if;
    #1;
    ma_r   = MA_MemRead | MA_MemWrite;
    exp_if = IF_Req_Valid && (!ma_r || stc_m == LIMIT);
    check("if_req_ready", IF_Req_Ready, exp_if);
    check("ma_req_ready", MA_Req_Ready, !exp_if && ma_r);
    check("conflict_cnt", Conflict_Cnt, cc_m);
    if (IF_Req_Valid && ma_r) cc_m++;
    if (exp_if) begin
      e = '{own: 1'b0, wr: 1'b0, addr: IF_Addr, data: 32'd0, strb: 4'd0};
      stc_m = 0;
    end else begin
      e = '{own: 1'b1, wr: MA_MemWrite, addr: MA_Addr, data: MA_Write_data, strb: MA_Write_strb};
      if (IF_Req_Valid && stc_m < LIMIT) stc_m++;
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Called at the negedge of the first REQ cycle; plays the memory side.
  task automatic run_txn(input int req_wait, input logic [31:0] rdata, input int resp_stall);
    txn_t e;
    int   mr;
    e  = sb_q.pop_front();
    mr = 0;
    for (int i = 0; i <= req_wait; i++) begin
      Mem_Req_Ready = (i == req_wait);
      #1;
      check("address", Address, e.addr);
      check("memwrite", MemWrite, e.wr);
      check("write_data", Write_data, e.data);
      check("write_strb", Write_strb, e.strb);
      check("req_ready_busy", {IF_Req_Ready, MA_Req_Ready}, 0);
      if (MemRead) mr++;
      @(negedge clk);
    end
    Mem_Req_Ready = 1'b0;
    check("memread_cycles", mr, e.wr ? 0 : req_wait + 1);
    if (!e.wr) begin
      Read_data       = rdata;
      Read_data_Valid = 1'b1;
      for (int i = 0; i <= resp_stall; i++) begin
        if (e.own) MA_Read_data_Ready = (i == resp_stall);
        else       IF_Read_data_Ready = (i == resp_stall);
        #1;
        check("owner_valid", e.own ? MA_Read_data_Valid : IF_Read_data_Valid, 1);
        check("other_valid", e.own ? IF_Read_data_Valid : MA_Read_data_Valid, 0);
        check("read_data_ready", Read_data_Ready, i == resp_stall);
        check("owner_read_data", e.own ? MA_Read_data : IF_Read_data, rdata);
        @(negedge clk);
      end
      IF_Read_data_Ready = 1'b1;
      MA_Read_data_Ready = 1'b1;
    end
    #1;
    check("idle_mem_ctrl", {MemRead, MemWrite}, 0);
    check("idle_strb", Write_strb, 0);
    check("idle_address_hold", Address, e.addr);
    check("idle_resp_valid", {IF_Read_data_Valid, MA_Read_data_Valid}, 0);
    check("idle_read_ready", Read_data_Ready, 0);
    Read_data_Valid = 1'b0;
    $display("txn %0d owner=%s %s addr=%h data=%h strb=%b", txn_no, e.own ? "MA" : "IF",
             e.wr ? "write" : "read", e.addr, e.wr ? e.data : rdata, e.strb);
    txn_no++;
  endtask

  initial begin
    rst = 1'b0;
    IF_Addr = '0; IF_Req_Valid = 1'b0; IF_Read_data_Ready = 1'b1;
    MA_Addr = '0; MA_MemRead = 1'b0; MA_MemWrite = 1'b0;
    MA_Write_data = '0; MA_Write_strb = '0; MA_Read_data_Ready = 1'b1;
    Mem_Req_Ready = 1'b0; Read_data = '0; Read_data_Valid = 1'b0;

    // Reset: outputs held at zero even with requests and a response present
    repeat (2) @(negedge clk);
    IF_Req_Valid = 1'b1; MA_MemRead = 1'b1; Read_data = 32'h5A5A_0001; Read_data_Valid = 1'b1;
    #1;
    check("rst_req_ready", {IF_Req_Ready, MA_Req_Ready}, 0);
    check("rst_mem_ctrl", {MemRead, MemWrite}, 0);
    check("rst_address", Address, 0);
    check("rst_write_data", Write_data, 0);
    check("rst_strb", Write_strb, 0);
    check("rst_resp", {Read_data_Ready, IF_Read_data_Valid, MA_Read_data_Valid}, 0);
    check("rst_conflict_cnt", Conflict_Cnt, 0);
    check("rst_passthrough", IF_Read_data, 32'h5A5A_0001);
    IF_Req_Valid = 1'b0; MA_MemRead = 1'b0; Read_data_Valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Lone IF fetch with delayed memory acceptance
    IF_Addr = 32'h0000_0100; IF_Req_Valid = 1'b1;
    grant_step();
    IF_Req_Valid = 1'b0;
    run_txn(2, 32'h0000_0013, 0);

    // MA store with MemRead also high: write wins, no response phase
    MA_Addr = 32'h0000_0200; MA_Write_data = 32'hDEAD_BEEF; MA_Write_strb = 4'b0011;
    MA_MemRead = 1'b1; MA_MemWrite = 1'b1;
    grant_step();
    MA_MemRead = 1'b0; MA_MemWrite = 1'b0;
    run_txn(1, 32'h0, 0);

    // Continuous contention: MA x4 then IF, repeating
    IF_Addr = 32'h0000_0400; IF_Req_Valid = 1'b1;
    MA_Addr = 32'h0000_0800; MA_MemRead = 1'b1; MA_Write_data = 32'h1111_2222; MA_Write_strb = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("grant_order_if", IF_Req_Ready, (k % 5) == 4);
      grant_step();
      run_txn(0, 32'h0000_1000 + k, 0);
    end
    IF_Req_Valid = 1'b0; MA_MemRead = 1'b0;

    // MA load with response backpressure
    MA_Addr = 32'h0000_0300; MA_MemRead = 1'b1;
    grant_step();
    MA_MemRead = 1'b0;
    run_txn(0, 32'hCAFE_F00D, 3);

    // Build up the starve count, then reset during the REQ of an MA load
    IF_Addr = 32'h0000_0500; IF_Req_Valid = 1'b1;
    MA_Addr = 32'h0000_0600; MA_MemRead = 1'b1;
    for (int k = 0; k < 3; k++) begin
      grant_step();
      run_txn(0, 32'h0000_2000 + k, 0);
    end
    grant_step();
    IF_Req_Valid = 1'b0; MA_MemRead = 1'b0;
    #1;
    check("pre_reset_memread", MemRead, 1);
    void'(sb_q.pop_front());
    rst = 1'b0;
    #1;
    check("mid_rst_mem_ctrl", {MemRead, MemWrite}, 0);
    check("mid_rst_address", Address, 0);
    check("mid_rst_conflict_cnt", Conflict_Cnt, 0);
    Read_data_Valid = 1'b1;
    #1;
    check("mid_rst_resp", {Read_data_Ready, IF_Read_data_Valid, MA_Read_data_Valid}, 0);
    cc_m = 0; stc_m = 0;
    @(negedge clk);
    rst = 1'b1; Read_data_Valid = 1'b0;
    @(negedge clk);

    // After reset the starve count is clear, so a conflict goes to MA
    IF_Req_Valid = 1'b1; MA_MemRead = 1'b1; MA_Addr = 32'h0000_0700;
    #1;
    check("post_rst_conflict_to_ma", MA_Req_Ready, 1);
    grant_step();
    IF_Req_Valid = 1'b0; MA_MemRead = 1'b0;
    run_txn(0, 32'h0000_0077, 0);

    // New IF request granted from IDLE
    IF_Addr = 32'h0000_0900; IF_Req_Valid = 1'b1;
    grant_step();
    IF_Req_Valid = 1'b0;
    run_txn(0, 32'h0000_0088, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory request/response port between the instruction-fetch stage (read-only) and the memory-access stage (load/store) of the turbo RISC-V pipeline. It grants one requester at a time, latches the granted request, drives the memory request channel from registers, and routes the read response back to its owner. There is one outstanding transaction at a time, MA has priority, and a starvation guard protects IF.

## Interface
- STARVE_LIMIT, 4: consecutive MA-wins-over-IF conflicts after which IF is granted next; range 1..15.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- IF_Addr  in  32  fetch address
- IF_Req_Valid  in  1  fetch read request
- IF_Req_Ready  out  1  fetch request accepted this cycle
- IF_Read_data  out  32  response data (mirror of Read_data)
- IF_Read_data_Valid  out  1  response valid for IF
- IF_Read_data_Ready  in  1  IF can take response
- MA_Addr  in  32  load/store address
- MA_MemRead, MA_MemWrite  in  1 each  MA request type; both high means write
- MA_Write_data  in  32; MA_Write_strb  in  4
- MA_Req_Ready  out  1  MA request accepted this cycle
- MA_Read_data  out  32; MA_Read_data_Valid  out  1; MA_Read_data_Ready  in  1
- Address  out  32; MemRead, MemWrite  out  1 each; Write_data  out  32; Write_strb  out  4
- Mem_Req_Ready  in  1  memory accepted request
- Read_data  in  32; Read_data_Valid  in  1; Read_data_Ready  out  1
- Conflict_Cnt  out  32  cycles in IDLE with both requesters asking; wraps

## Operation
- States: IDLE, REQ, RESP. Owner register OWN holds IF or MA. Request registers: AR (32 bits), WR (1 bit, write flag), DR (32 bits), SR (4 bits).
- IDLE:
  - Arbitrate among IF_Req_Valid and MA_req = MA_MemRead|MA_MemWrite.
  - MA wins unless IF is also requesting and starve count STC == STARVE_LIMIT.
  - Winner's *_Req_Ready is high combinationally. At the edge: latch the winner's fields into AR/WR/DR/SR, set OWN, go to REQ.
  - IF grants force WR=0, DR=0, SR=0.
- STC (4-bit):
  - On a conflict grant to MA: +1, saturating at STARVE_LIMIT.
  - On any grant to IF: cleared to 0.
  - Unchanged otherwise.
- REQ:
  - Address=AR. MemWrite=WR. MemRead=~WR. Write_data=DR. Write_strb=SR.
  - Hold these until Mem_Req_Ready.
  - On Mem_Req_Ready: go to IDLE if WR, otherwise to RESP.
- RESP:
  - Read_data_Ready = OWN's *_Read_data_Ready.
  - OWN's *_Read_data_Valid = Read_data_Valid. The other requester's valid stays 0.
  - On Read_data_Valid & Read_data_Ready: go to IDLE.
- Outside REQ: MemRead=MemWrite=0, Write_strb=0. Address and Write_data hold AR and DR.
- Outside RESP: Read_data_Ready=0 and both *_Read_data_Valid=0.
- *_Read_data outputs pass Read_data through unconditionally.
- *_Req_Ready is 0 outside IDLE. Requests arriving in REQ/RESP wait; requesters hold them until their Ready.
- Conflict_Cnt increments in every IDLE cycle with IF_Req_Valid & MA_req, including stalled-free grant cycles.

## Timing
- Reset (rst low, asynchronous):
  - State=IDLE; OWN=IF; STC=0; AR/DR/SR/WR=0; Conflict_Cnt=0.
  - All outputs 0 except the *_Read_data passthroughs.
  - Reset mid-transaction abandons it; no response is routed afterward.
- Grant latency: request seen in IDLE at cycle N is accepted at edge N; MemRead/MemWrite are high from cycle N+1.
- Minimum write: 2 cycles (IDLE, REQ with Mem_Req_Ready). Minimum read: 3 cycles (IDLE, REQ, RESP with valid & ready).
- No back-to-back grant: IDLE is always visited for at least one cycle between transactions.
- A response valid while the owner's ready is low stays in RESP; the memory side holds the data.
- Simultaneous IF and MA in IDLE with STC<STARVE_LIMIT: MA wins. With STC==STARVE_LIMIT: IF wins and STC clears.

## Test plan
- Lone IF fetch, Addr=0x0000_0100, Mem_Req_Ready delayed 2 cycles, Read_data=0x0000_0013 -> MemRead high 3 cycles; IF_Read_data_Valid pulses once with 0x13; MA_Read_data_Valid stays 0.
- MA store, Addr=0x200, data=0xDEADBEEF, strb=4'b0011, MemRead also high -> MemWrite=1, MemRead=0, Write_strb=0011; back to IDLE after Mem_Req_Ready, no RESP state.
- IF and MA requesting continuously, STARVE_LIMIT=4, zero-wait memory -> grants in the order MA,MA,MA,MA,IF, repeating; Conflict_Cnt increments once per IDLE cycle.
- Response backpressure: MA load with MA_Read_data_Ready low for 3 cycles after Read_data_Valid -> stays in RESP, Read_data_Ready=0 until MA is ready, single completion.
- rst pulled low during REQ of an MA load -> outputs immediately 0. After release, a new IF request is granted from IDLE with STC=0 and Conflict_Cnt=0.
